spi_slave_framed: RTL

//  Parametrised SPI slave. Deserialises MSB-first MOSI frames of CMD_W command bits plus DATA_W data bits.

---
 rtl/spi_slave_pkg.sv | 13 +
 rtl/spi_shift_reg.sv | 28 ++
 rtl/spi_slave_framed.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the framed SPI slave.
`timescale 1ns/1ps
package spi_slave_pkg;
    typedef enum logic [1:0] {IDLE, RECV, WAIT_TX, SEND} state_e;

    localparam int DEF_CMD_W  = 2;
    localparam int DEF_DATA_W = 8;
    localparam logic [DEF_CMD_W-1:0] DEF_RD_CMD = 2'b11;

    function automatic int min1(input int v);
        return (v < 1) ? 1 : v;
    endfunction
endpackage

// File: rtl/spi_shift_reg.sv
// Load/shift register: parallel load or MSB-first shift with serial-in at the LSB.
`timescale 1ns/1ps
module spi_shift_reg
    import spi_slave_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_shift,
    input  logic         i_sin,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    // Clear beats load beats shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_q <= '0;
        else if (i_clr)   r_q <= '0;
        else if (i_load)  r_q <= i_load_val;
        else if (i_shift) r_q <= {r_q[W-2:0], i_sin};
    end

    assign o_q = r_q;
endmodule

// File: rtl/spi_slave_framed.sv
// SPI slave: MSB-first {cmd,data} frames in on MOSI, optional DATA_W read-back out on MISO.
`timescale 1ns/1ps
module spi_slave_framed
    import spi_slave_pkg::*;
#(
    parameter int                CMD_W      = DEF_CMD_W,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter logic [CMD_W-1:0]  RD_CMD     = CMD_W'(DEF_RD_CMD),
    parameter int                TX_TIMEOUT = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ss_n,
    input  logic                      mosi,
    output logic                      miso,
    output logic [CMD_W+DATA_W-1:0]   rx_data,
    output logic                      rx_valid,
    input  logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      frame_err,
    output logic                      busy
);
    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TO_W    = min1($clog2(TX_TIMEOUT + 1));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_SEND = CNT_W'(DATA_W);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0);

    state_e               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
    logic [TO_W-1:0]      r_to_cnt, w_to_cnt_nxt;
    logic                 r_miso, w_miso_nxt;
    logic [FRAME_W-1:0]   r_rx_data;
    logic                 r_rx_valid, w_rx_valid_nxt;
    logic                 r_tx_ready, w_tx_ready_nxt;
    logic                 r_frame_err, w_frame_err_nxt;
    logic                 w_rx_shift, w_rx_clr, w_tx_load, w_tx_shift, w_tx_clr;
    logic [FRAME_W-1:0]   w_rx_q, w_frame;
    logic [DATA_W-1:0]    w_tx_q;
    logic                 w_unused;

    spi_shift_reg #(.W(FRAME_W)) u_rx_sr (
        .clk(clk), .rst_n(rst_n), .i_clr(w_rx_clr), .i_load(1'b0), .i_load_val('0),
        .i_shift(w_rx_shift), .i_sin(mosi), .o_q(w_rx_q)
    );

    spi_shift_reg #(.W(DATA_W)) u_tx_sr (
        .clk(clk), .rst_n(rst_n), .i_clr(w_tx_clr), .i_load(w_tx_load), .i_load_val(tx_data),
        .i_shift(w_tx_shift), .i_sin(1'b0), .o_q(w_tx_q)
    );

    // Frame as it will look once the bit on mosi this edge is shifted in.
    assign w_frame  = {w_rx_q[FRAME_W-2:0], mosi};
    assign w_unused = &{1'b0, w_rx_q[FRAME_W-1], w_tx_q[DATA_W-2:0]};

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_to_cnt_nxt    = r_to_cnt;
        w_miso_nxt      = 1'b0;
        w_rx_valid_nxt  = 1'b0;
        w_tx_ready_nxt  = r_tx_ready;
        w_frame_err_nxt = 1'b0;
        w_rx_shift      = 1'b0;
        w_rx_clr        = 1'b0;
        w_tx_load       = 1'b0;
        w_tx_shift      = 1'b0;
        w_tx_clr        = 1'b0;
        if (ss_n) begin
            // Deselect aborts anything in flight; a RECV at bit_cnt 0 sits between frames.
            w_state_nxt     = IDLE;
            w_bit_cnt_nxt   = '0;
            w_to_cnt_nxt    = '0;
            w_tx_ready_nxt  = 1'b0;
            w_rx_clr        = 1'b1;
            w_tx_clr        = 1'b1;
            w_frame_err_nxt = (r_state == RECV && r_bit_cnt != '0) ||
                              (r_state == WAIT_TX) || (r_state == SEND);
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_rx_shift    = 1'b1;
                    w_bit_cnt_nxt = CNT_W'(1);
                    w_state_nxt   = RECV;
                end
                RECV: begin
                    w_rx_shift = 1'b1;
                    if (r_bit_cnt == CNT_LAST) begin
                        w_rx_valid_nxt = 1'b1;
                        w_bit_cnt_nxt  = '0;
                        if (w_frame[FRAME_W-1 -: CMD_W] == RD_CMD) begin
                            w_state_nxt    = WAIT_TX;
                            w_tx_ready_nxt = 1'b1;
                            w_to_cnt_nxt   = '0;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
                WAIT_TX: begin
                    if (tx_valid && r_tx_ready) begin
                        w_tx_load      = 1'b1;
                        w_tx_ready_nxt = 1'b0;
                        w_bit_cnt_nxt  = '0;
                        w_state_nxt    = SEND;
                    end else if (TX_TIMEOUT > 0 && r_to_cnt == TO_LAST) begin
                        w_frame_err_nxt = 1'b1;
                        w_tx_ready_nxt  = 1'b0;
                        w_to_cnt_nxt    = '0;
                        w_state_nxt     = IDLE;
                    end else if (TX_TIMEOUT > 0) begin
                        w_to_cnt_nxt = r_to_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (r_bit_cnt == CNT_SEND) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_miso_nxt    = w_tx_q[DATA_W-1];
                        w_tx_shift    = 1'b1;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_to_cnt    <= '0;
            r_miso      <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_miso      <= w_miso_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_tx_ready  <= w_tx_ready_nxt;
            r_frame_err <= w_frame_err_nxt;
            if (w_rx_valid_nxt) r_rx_data <= w_frame;
        end
    end

    assign miso      = r_miso;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign tx_ready  = r_tx_ready;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);
endmodule
